// File: rtl/adder_meas_pkg.sv
// adder_meas_pkg
// Shared definitions for the adder measurement controller: the FSM state
// encoding, the default operand-settle time and the datapath widths.
package adder_meas_pkg;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;
  localparam int unsigned WINDOW_W              = 16;
  localparam int unsigned DATA_W                = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_STOP,
    ST_CAPTURE
  } meas_state_t;

endpackage

// File: rtl/adder_meas_timer.sv
// adder_meas_timer
// Loadable down-counter with a zero flag. The controller loads it with
// (duration - 1) on entry to a timed state and decrements it each cycle.
// The count parks at zero rather than wrapping.
//
// Ports:
//   clock      - clock
//   reset      - asynchronous active-high reset
//   load       - load load_value (takes priority over dec)
//   load_value - value to load
//   dec        - decrement by one when not already zero
//   zero       - count is zero
module adder_meas_timer
  import adder_meas_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [WINDOW_W-1:0] load_value,
  input  logic                dec,
  output logic                zero
);

  logic [WINDOW_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WINDOW_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adder_measure_ctrl.sv
// adder_measure_ctrl
// Sequences one delay measurement of an instrumented adder: latch operands,
// clear the oscillation counter, let the operands settle, enable the ring
// for a window of clocks, let the counter quiesce, then capture sum and count.
//
// Ports:
//   wb_clk_i, wb_rst_i         - clock, asynchronous active-high reset
//   start, abort               - begin / cancel a measurement
//   a_value, b_value           - operands to apply
//   ext_sel_in                 - 0 ring path, 1 external chain path
//   window                     - ring-enable window in clocks (0 acts as 1)
//   sum_in, count_in           - adder sum and oscillation count to capture
//   adder_a, adder_b, ext_sel  - latched operands / path select to the adder
//   ring_en, counter_en        - ring oscillator and counter enables
//   counter_clr                - counter clear (during LOAD)
//   busy, done, aborted        - status; done/aborted are one-cycle pulses
//   result_sum, result_count   - captured results
//   count_sat                  - captured count is all ones
module adder_measure_ctrl
  import adder_meas_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   a_value,
  input  logic [DATA_W-1:0]   b_value,
  input  logic                ext_sel_in,
  input  logic [WINDOW_W-1:0] window,
  input  logic [DATA_W-1:0]   sum_in,
  input  logic [DATA_W-1:0]   count_in,
  output logic [DATA_W-1:0]   adder_a,
  output logic [DATA_W-1:0]   adder_b,
  output logic                ext_sel,
  output logic                ring_en,
  output logic                counter_en,
  output logic                counter_clr,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [DATA_W-1:0]   result_sum,
  output logic [DATA_W-1:0]   result_count,
  output logic                count_sat
);

  meas_state_t         state, state_next;
  logic [WINDOW_W-1:0] window_q;
  logic                stop_second;
  logic                timer_load, timer_dec, timer_zero;
  logic [WINDOW_W-1:0] timer_value;
  logic                latch_start, take_abort, capture;

  adder_meas_timer u_timer (
    .clock      (wb_clk_i),
    .reset      (wb_rst_i),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  // State register plus the small amount of per-measurement context:
  // the latched window (needed when RUN is entered) and which STOP cycle we are in.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      window_q    <= '0;
      stop_second <= 1'b0;
    end else begin
      state       <= state_next;
      stop_second <= (state == ST_STOP) && !stop_second;
      if (latch_start) begin
        window_q <= window;
      end
    end
  end

  // Next-state logic. The timer is loaded with (duration - 1) on the edge that
  // enters SETTLE or RUN, so the state exits on the cycle the timer reads zero.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    timer_dec   = 1'b0;
    latch_start = 1'b0;
    take_abort  = 1'b0;
    capture     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_start = 1'b1;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          take_abort = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_load  = 1'b1;
          timer_value = WINDOW_W'(SETTLE_CYCLES - 1);
          state_next  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          take_abort = 1'b1;
          state_next = ST_IDLE;
        end else if (timer_zero) begin
          timer_load  = 1'b1;
          // A zero window still gives one enabled cycle.
          timer_value = (window_q == '0) ? '0 : window_q - WINDOW_W'(1);
          state_next  = ST_RUN;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          take_abort = 1'b1;
          state_next = ST_IDLE;
        end else if (timer_zero) begin
          state_next = ST_STOP;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_STOP: begin
        if (stop_second) begin
          capture    = 1'b1;
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it belongs to and comes straight from a flop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adder_a      <= '0;
      adder_b      <= '0;
      ext_sel      <= 1'b0;
      ring_en      <= 1'b0;
      counter_en   <= 1'b0;
      counter_clr  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      result_sum   <= '0;
      result_count <= '0;
      count_sat    <= 1'b0;
    end else begin
      ring_en     <= (state_next == ST_RUN);
      counter_en  <= (state_next == ST_RUN);
      counter_clr <= (state_next == ST_LOAD);
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_CAPTURE);
      aborted     <= take_abort;
      if (latch_start) begin
        adder_a <= a_value;
        adder_b <= b_value;
        ext_sel <= ext_sel_in;
      end
      if (capture) begin
        result_sum   <= sum_in;
        result_count <= count_in;
        count_sat    <= &count_in;
      end
    end
  end

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// tb_adder_measure_ctrl
// Directed bench for adder_measure_ctrl. A timeline model derives each cycle's
// expected outputs from the start cycle, window and abort cycle of the current
// measurement; a negedge process compares every output each cycle. Literal
// expectations (latencies, ring-enable counts, captured values) pin the model.
module tb_adder_measure_ctrl;

  localparam int S = 4;

  typedef enum {P_IDLE, P_LOAD, P_SETTLE, P_RUN, P_STOP, P_CAPT} phase_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start = 1'b0, abort = 1'b0, ext_sel_in = 1'b0;
  logic [31:0] a_value = '0, b_value = '0, sum_in = '0, count_in = '0;
  logic [15:0] window = '0;
  logic [31:0] adder_a, adder_b, result_sum, result_count;
  logic        ext_sel, ring_en, counter_en, counter_clr, busy, done, aborted, count_sat;

  adder_measure_ctrl #(.SETTLE_CYCLES(S)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .start        (start),
    .abort        (abort),
    .a_value      (a_value),
    .b_value      (b_value),
    .ext_sel_in   (ext_sel_in),
    .window       (window),
    .sum_in       (sum_in),
    .count_in     (count_in),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .ext_sel      (ext_sel),
    .ring_en      (ring_en),
    .counter_en   (counter_en),
    .counter_clr  (counter_clr),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .result_sum   (result_sum),
    .result_count (result_count),
    .count_sat    (count_sat)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model of the accepted measurement
  bit          tx_valid = 1'b0;
  int          tx_n = 0, tx_w = 0, tx_abort = -1;
  logic [31:0] tx_a = '0, tx_b = '0;
  logic        tx_sel = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, r_sum = '0, r_cnt = '0, last_sum = '0, last_cnt = '0;
  logic        m_sel = 1'b0;
  int          done_cyc = -1, done_cnt = 0, ring_hi = 0, aborted_cnt = 0;
  phase_t      ph;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
    end
  endtask

  // Where the measurement stands in cycle c, purely from its timeline.
  function automatic phase_t phaseAt(input int c);
    int rel, w;
    if (!tx_valid) return P_IDLE;
    if (tx_abort >= 0 && c > tx_abort) return P_IDLE;
    rel = c - tx_n;
    w = (tx_w == 0) ? 1 : tx_w;
    if (rel < 1) return P_IDLE;
    if (rel == 1) return P_LOAD;
    if (rel <= S + 1) return P_SETTLE;
    if (rel <= S + 1 + w) return P_RUN;
    if (rel <= S + 3 + w) return P_STOP;
    if (rel == S + 4 + w) return P_CAPT;
    return P_IDLE;
  endfunction

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ph = phaseAt(cyc);
      if (ph == P_LOAD) begin
        m_a = tx_a; m_b = tx_b; m_sel = tx_sel;
      end
      if (ph == P_CAPT) begin
        r_sum = last_sum; r_cnt = last_cnt;
      end
      last_sum = sum_in;
      last_cnt = count_in;
      if (done === 1'b1) begin
        done_cyc = cyc; done_cnt++;
      end
      if (ring_en === 1'b1) ring_hi++;
      if (aborted === 1'b1) aborted_cnt++;
      checkOutput("busy", 64'(busy), 64'(ph != P_IDLE));
      checkOutput("ring_en", 64'(ring_en), 64'(ph == P_RUN));
      checkOutput("counter_en", 64'(counter_en), 64'(ph == P_RUN));
      checkOutput("counter_clr", 64'(counter_clr), 64'(ph == P_LOAD));
      checkOutput("done", 64'(done), 64'(ph == P_CAPT));
      checkOutput("aborted", 64'(aborted), 64'(tx_valid && tx_abort >= 0 && cyc == tx_abort + 1));
      checkOutput("adder_a", 64'(adder_a), 64'(m_a));
      checkOutput("adder_b", 64'(adder_b), 64'(m_b));
      checkOutput("ext_sel", 64'(ext_sel), 64'(m_sel));
      checkOutput("result_sum", 64'(result_sum), 64'(r_sum));
      checkOutput("result_count", 64'(result_count), 64'(r_cnt));
      checkOutput("count_sat", 64'(count_sat), 64'(r_cnt == 32'hFFFF_FFFF));
    end
  end

  // Pulse start for one cycle; the model accepts it only if it is idle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sel,
                               input logic [15:0] w, input logic with_abort);
    a_value = a; b_value = b; ext_sel_in = sel; window = w;
    start = 1'b1; abort = with_abort;
    if (phaseAt(cyc) == P_IDLE) begin
      tx_valid = 1'b1; tx_n = cyc; tx_w = int'(w); tx_abort = -1;
      tx_a = a; tx_b = b; tx_sel = sel;
      ring_hi = 0; done_cyc = -1;
    end
    @(posedge wb_clk_i); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic raiseAbort();
    phase_t p;
    p = phaseAt(cyc);
    abort = 1'b1;
    if ((p == P_LOAD || p == P_SETTLE || p == P_RUN) && tx_abort < 0) tx_abort = cyc;
    @(posedge wb_clk_i); #1;
    abort = 1'b0;
  endtask

  int n, dc0, ac0;

  initial begin
    // Reset state
    #3;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_adder_a", 64'(adder_a), 64'd0);
    checkOutput("rst_result_sum", 64'(result_sum), 64'd0);
    checkOutput("rst_ring_en", 64'(ring_en), 64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    repeat (2) @(posedge wb_clk_i); #1;

    // Basic measurement
    sum_in = 32'd12; count_in = 32'd1234;
    applyStimulus(32'd5, 32'd7, 1'b0, 16'd10, 1'b0);
    n = tx_n;
    checkOutput("basic_adder_a_load", 64'(adder_a), 64'd5);
    checkOutput("basic_adder_b_load", 64'(adder_b), 64'd7);
    repeat (20) @(posedge wb_clk_i); #1;
    checkOutput("basic_done_lat", 64'(done_cyc - n), 64'd18);
    checkOutput("basic_ring_cycles", 64'(ring_hi), 64'd10);
    checkOutput("basic_sum", 64'(result_sum), 64'd12);
    checkOutput("basic_count", 64'(result_count), 64'd1234);
    checkOutput("basic_sat", 64'(count_sat), 64'd0);

    // Zero window, external path
    sum_in = 32'd7; count_in = 32'd55;
    applyStimulus(32'd3, 32'd4, 1'b1, 16'd0, 1'b0);
    n = tx_n;
    repeat (12) @(posedge wb_clk_i); #1;
    checkOutput("zero_done_lat", 64'(done_cyc - n), 64'd9);
    checkOutput("zero_ring_cycles", 64'(ring_hi), 64'd1);
    checkOutput("zero_ext_sel", 64'(ext_sel), 64'd1);
    checkOutput("zero_count", 64'(result_count), 64'd55);

    // Start while busy is ignored
    sum_in = 32'd12; count_in = 32'd1234;
    dc0 = done_cnt;
    applyStimulus(32'd5, 32'd7, 1'b0, 16'd10, 1'b0);
    repeat (6) @(posedge wb_clk_i); #1;
    applyStimulus(32'd9, 32'd2, 1'b1, 16'd3, 1'b0);
    checkOutput("busy_start_adder_a", 64'(adder_a), 64'd5);
    repeat (15) @(posedge wb_clk_i); #1;
    checkOutput("busy_start_one_done", 64'(done_cnt - dc0), 64'd1);
    checkOutput("busy_start_sum", 64'(result_sum), 64'd12);

    // Abort in the third RUN cycle
    sum_in = 32'd99; count_in = 32'd77;
    dc0 = done_cnt; ac0 = aborted_cnt;
    applyStimulus(32'd6, 32'd6, 1'b0, 16'd10, 1'b0);
    repeat (7) @(posedge wb_clk_i); #1;
    raiseAbort();
    checkOutput("abort_ring_en", 64'(ring_en), 64'd0);
    checkOutput("abort_pulse", 64'(aborted), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    repeat (15) @(posedge wb_clk_i); #1;
    checkOutput("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    checkOutput("abort_one_pulse", 64'(aborted_cnt - ac0), 64'd1);
    checkOutput("abort_sum_kept", 64'(result_sum), 64'd12);
    checkOutput("abort_count_kept", 64'(result_count), 64'd1234);

    // Reset between edges mid-RUN, then start (with abort also high) afterwards
    sum_in = 32'd21; count_in = 32'd3;
    applyStimulus(32'd1, 32'd2, 1'b1, 16'd20, 1'b0);
    repeat (8) @(posedge wb_clk_i); #2;
    wb_rst_i = 1'b1;
    tx_valid = 1'b0; m_a = '0; m_b = '0; m_sel = 1'b0; r_sum = '0; r_cnt = '0;
    #1;
    checkOutput("rst_run_ring_en", 64'(ring_en), 64'd0);
    checkOutput("rst_run_busy", 64'(busy), 64'd0);
    checkOutput("rst_run_adder_a", 64'(adder_a), 64'd0);
    checkOutput("rst_run_ext_sel", 64'(ext_sel), 64'd0);
    checkOutput("rst_run_sum", 64'(result_sum), 64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    repeat (2) @(posedge wb_clk_i); #1;
    applyStimulus(32'd8, 32'd8, 1'b0, 16'd5, 1'b1);
    n = tx_n;
    repeat (16) @(posedge wb_clk_i); #1;
    checkOutput("post_rst_done_lat", 64'(done_cyc - n), 64'd13);
    checkOutput("post_rst_ring_cycles", 64'(ring_hi), 64'd5);
    checkOutput("post_rst_sum", 64'(result_sum), 64'd21);

    // Maximum window with saturated count
    sum_in = 32'h0000_DEAD; count_in = 32'hFFFF_FFFF;
    applyStimulus(32'd1, 32'd1, 1'b0, 16'hFFFF, 1'b0);
    n = tx_n;
    repeat (65550) @(posedge wb_clk_i); #1;
    checkOutput("sat_done_lat", 64'(done_cyc - n), 64'd65543);
    checkOutput("sat_ring_cycles", 64'(ring_hi), 64'd65535);
    checkOutput("sat_flag", 64'(count_sat), 64'd1);
    checkOutput("sat_count", 64'(result_count), 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
